// File: rtl/seq_csa_add64_ctrl.sv
// Multi-cycle WIDTH-bit adder that reuses one 16-bit carry-select slice over WIDTH/16 passes.
// Define SEQ_CSA_OVF_EN to add the registered signed-overflow output.
module seq_csa_add64_ctrl #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
`ifdef SEQ_CSA_OVF_EN
  output logic             overflow,
`endif
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / 16;
  localparam int unsigned IdxW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             cy_q, cy_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             ready_q, ready_d, valid_q, valid_d, busy_q, busy_d;

  // Shared slice: 8-bit ripple low half, high half precomputed for both carries.
  logic [15:0] sl_a, sl_b, sl_sum;
  logic [8:0]  lo, hi0, hi1;
  logic        sl_cout;

  always_comb begin
    sl_a    = a_q[16*idx_q +: 16];
    sl_b    = b_q[16*idx_q +: 16];
    lo      = {1'b0, sl_a[7:0]} + {1'b0, sl_b[7:0]} + {8'd0, cy_q};
    hi0     = {1'b0, sl_a[15:8]} + {1'b0, sl_b[15:8]};
    hi1     = {1'b0, sl_a[15:8]} + {1'b0, sl_b[15:8]} + 9'd1;
    sl_sum  = lo[8] ? {hi1[7:0], lo[7:0]} : {hi0[7:0], lo[7:0]};
    sl_cout = lo[8] ? hi1[8] : hi0[8];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (in_valid && ready_q) begin
          a_d     = a;
          b_d     = b;
          cy_d    = carry_in;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[16*idx_q +: 16] = sl_sum;
        cy_d  = sl_cout;
        idx_d = idx_q + IdxW'(1);
        if (idx_q == IdxW'(NSLICE - 1)) begin
          cout_d  = sl_cout;
          // Carry into the MSB is recovered from the MSB sum bit.
          ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sl_sum[15] ^ sl_cout;
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Handshake outputs are registered copies of the next-state decode.
    ready_d = (state_d == StIdle);
    valid_d = (state_d == StDone);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;
`ifdef SEQ_CSA_OVF_EN
  assign overflow  = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule
